pe: RTL and testbench

PE -- requirements
Module: pe

---
 rtl/pe.sv | 132 +++++++++++++
 tb/tb_pe.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pe.sv
// Radix-2 DIT complex butterfly processing element.
// Two-stage pipeline: stage 1 forms the twiddle product W*B (full precision,
// truncated to the Q format and saturated); stage 2 forms A +/- W*B with
// saturation. Outputs are registered; latency is two clock cycles.
module pe #(
    parameter int WORDSIZE = 16,
    parameter int WL       = 16,
    parameter int IWL      = 5,
    parameter int FWL      = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [WORDSIZE-1:0] in0_r,
    input  logic [WORDSIZE-1:0] in1_r,
    input  logic [WORDSIZE-1:0] in2_r,
    input  logic [WORDSIZE-1:0] in3_r,
    input  logic [WORDSIZE-1:0] twiddle_r,
    input  logic [WORDSIZE-1:0] twiddle_i,
    output logic [WORDSIZE-1:0] out0,
    output logic [WORDSIZE-1:0] out1,
    output logic [WORDSIZE-1:0] out2,
    output logic [WORDSIZE-1:0] out3
);

    // The fixed-point format must fill the data word exactly.
    if (WL != WORDSIZE || WL != 1 + IWL + FWL) begin : g_param_check
        $error("pe: WL must equal WORDSIZE and 1+IWL+FWL");
    end

    // Clamp a (2*WL+1)-bit signed value into the WL-bit signed range.
    function automatic logic [WL-1:0] sat_wide(input logic signed [2*WL:0] v);
        logic [WL+1:0] top;
        top = v[2*WL:WL-1];
        if (top == '0 || top == '1) begin
            return v[WL-1:0];
        end else if (v[2*WL]) begin
            return {1'b1, {(WL-1){1'b0}}};
        end else begin
            return {1'b0, {(WL-1){1'b1}}};
        end
    endfunction

    // Clamp a (WL+1)-bit signed sum into the WL-bit signed range.
    function automatic logic [WL-1:0] sat_narrow(input logic [WL:0] v);
        if (v[WL] == v[WL-1]) begin
            return v[WL-1:0];
        end else if (v[WL]) begin
            return {1'b1, {(WL-1){1'b0}}};
        end else begin
            return {1'b0, {(WL-1){1'b1}}};
        end
    endfunction

    // Signed views of the inputs
    logic signed [WL-1:0]   wr_s, wi_s, br_s, bi_s;
    // Full-precision partial products and their sign-extended forms
    logic signed [2*WL-1:0] p_rr, p_ii, p_ri, p_ir;
    logic signed [2*WL:0]   p_rr_x, p_ii_x, p_ri_x, p_ir_x;
    logic signed [2*WL:0]   tr_full, ti_full, tr_sh, ti_sh;

    // Pipeline registers
    logic [WL-1:0] tr_q, ti_q, ar_q, ai_q;
    logic [WL-1:0] tr_d, ti_d;
    logic [WL-1:0] out0_q, out1_q, out2_q, out3_q;
    logic [WL-1:0] out0_d, out1_d, out2_d, out3_d;

    // Stage-2 wide sums/differences
    logic [WL:0] s0, s1, s2, s3;

    // Stage 1 combinational: complex product W*B, truncate, saturate
    always_comb begin
        wr_s    = twiddle_r;
        wi_s    = twiddle_i;
        br_s    = in2_r;
        bi_s    = in3_r;
        p_rr    = wr_s * br_s;
        p_ii    = wi_s * bi_s;
        p_ri    = wr_s * bi_s;
        p_ir    = wi_s * br_s;
        p_rr_x  = {p_rr[2*WL-1], p_rr};
        p_ii_x  = {p_ii[2*WL-1], p_ii};
        p_ri_x  = {p_ri[2*WL-1], p_ri};
        p_ir_x  = {p_ir[2*WL-1], p_ir};
        tr_full = p_rr_x - p_ii_x;
        ti_full = p_ri_x + p_ir_x;
        tr_sh   = tr_full >>> FWL;
        ti_sh   = ti_full >>> FWL;
        tr_d    = sat_wide(tr_sh);
        ti_d    = sat_wide(ti_sh);
    end

    // Stage 2 combinational: A +/- W*B at WL+1 bits, then saturate
    always_comb begin
        s0     = {ar_q[WL-1], ar_q} + {tr_q[WL-1], tr_q};
        s1     = {ai_q[WL-1], ai_q} + {ti_q[WL-1], ti_q};
        s2     = {ar_q[WL-1], ar_q} - {tr_q[WL-1], tr_q};
        s3     = {ai_q[WL-1], ai_q} - {ti_q[WL-1], ti_q};
        out0_d = sat_narrow(s0);
        out1_d = sat_narrow(s1);
        out2_d = sat_narrow(s2);
        out3_d = sat_narrow(s3);
    end

    // Pipeline registers for both stages, cleared asynchronously by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tr_q   <= '0;
            ti_q   <= '0;
            ar_q   <= '0;
            ai_q   <= '0;
            out0_q <= '0;
            out1_q <= '0;
            out2_q <= '0;
            out3_q <= '0;
        end else begin
            tr_q   <= tr_d;
            ti_q   <= ti_d;
            ar_q   <= in0_r;
            ai_q   <= in1_r;
            out0_q <= out0_d;
            out1_q <= out1_d;
            out2_q <= out2_d;
            out3_q <= out3_d;
        end
    end

    assign out0 = out0_q;
    assign out1 = out1_q;
    assign out2 = out2_q;
    assign out3 = out3_q;

endmodule

// File: tb/tb_pe.sv
// Directed testbench for the pe butterfly.
module tb_pe;

    logic        clk;
    logic        rst_n;
    logic [15:0] in0_r, in1_r, in2_r, in3_r, twiddle_r, twiddle_i;
    logic [15:0] out0, out1, out2, out3;

    int tests;
    int fails;

    pe #(.WORDSIZE(16), .WL(16), .IWL(5), .FWL(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in0_r     (in0_r),
        .in1_r     (in1_r),
        .in2_r     (in2_r),
        .in3_r     (in3_r),
        .twiddle_r (twiddle_r),
        .twiddle_i (twiddle_i),
        .out0      (out0),
        .out1      (out1),
        .out2      (out2),
        .out3      (out3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog: the directed sequence is short; anything beyond this is a hang.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (obs=timeout exp=finish)");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one butterfly's operands (called right after a negedge).
    task automatic drive(input logic [15:0] wr, input logic [15:0] wi,
                         input logic [15:0] ar, input logic [15:0] ai,
                         input logic [15:0] br, input logic [15:0] bi);
        twiddle_r = wr;
        twiddle_i = wi;
        in0_r     = ar;
        in1_r     = ai;
        in2_r     = br;
        in3_r     = bi;
    endtask

    // Two sampling edges, then observe on the following falling edge.
    task automatic wait_latency();
        repeat (2) @(posedge clk);
        @(negedge clk);
    endtask

    // Behavioural reference: integer arithmetic with explicit clamping.
    function automatic logic [15:0] clamp16(input longint v);
        if (v > 32767) return 16'h7FFF;
        if (v < -32768) return 16'h8000;
        return v[15:0];
    endfunction

    function automatic logic [63:0] ref_bfly(input logic [15:0] wr, input logic [15:0] wi,
                                             input logic [15:0] ar, input logic [15:0] ai,
                                             input logic [15:0] br, input logic [15:0] bi);
        longint lwr, lwi, lar, lai, lbr, lbi, tr, ti, trs, tis;
        lwr = longint'($signed(wr));
        lwi = longint'($signed(wi));
        lar = longint'($signed(ar));
        lai = longint'($signed(ai));
        lbr = longint'($signed(br));
        lbi = longint'($signed(bi));
        tr  = lwr * lbr - lwi * lbi;
        ti  = lwr * lbi + lwi * lbr;
        trs = longint'(clamp16(tr >>> 10));
        tis = longint'(clamp16(ti >>> 10));
        trs = longint'($signed(trs[15:0]));
        tis = longint'($signed(tis[15:0]));
        return {clamp16(lar + trs), clamp16(lai + tis), clamp16(lar - trs), clamp16(lai - tis)};
    endfunction

    logic [15:0] vec [10][6];
    logic [63:0] expv;

    initial begin
        tests = 0;
        fails = 0;
        drive('0, '0, '0, '0, '0, '0);
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        // Reset state without any clock edge
        chk("rst_out0", out0, 16'h0000);
        chk("rst_out1", out1, 16'h0000);
        chk("rst_out2", out2, 16'h0000);
        chk("rst_out3", out3, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        // Identity twiddle
        drive(16'h0400, 16'h0000, 16'h0002, 16'h110B, 16'h100C, 16'h000E);
        wait_latency();
        chk("ident_out0", out0, 16'h100E);
        chk("ident_out1", out1, 16'h1119);
        chk("ident_out2", out2, 16'hEFF6);
        chk("ident_out3", out3, 16'h10FD);

        // Twiddle -j
        drive(16'h0000, 16'hFC00, 16'h0000, 16'h0000, 16'h0400, 16'h0800);
        wait_latency();
        chk("negj_out0", out0, 16'h0800);
        chk("negj_out1", out1, 16'hFC00);
        chk("negj_out2", out2, 16'hF800);
        chk("negj_out3", out3, 16'h0400);

        // Saturating addition
        drive(16'h0400, 16'h0000, 16'h7000, 16'h0000, 16'h2000, 16'h0000);
        wait_latency();
        chk("addsat_out0", out0, 16'h7FFF);
        chk("addsat_out1", out1, 16'h0000);
        chk("addsat_out2", out2, 16'h5000);
        chk("addsat_out3", out3, 16'h0000);

        // Truncation toward minus infinity, positive operand
        drive(16'h0200, 16'h0000, 16'h0000, 16'h0000, 16'h0003, 16'h0000);
        wait_latency();
        chk("trunc_pos_out0", out0, 16'h0001);
        chk("trunc_pos_out2", out2, 16'hFFFF);

        // Truncation toward minus infinity, negative operand
        drive(16'h0200, 16'h0000, 16'h0000, 16'h0000, 16'hFFFD, 16'h0000);
        wait_latency();
        chk("trunc_neg_out0", out0, 16'hFFFE);
        chk("trunc_neg_out2", out2, 16'h0002);

        // Product saturation
        drive(16'h8000, 16'h8000, 16'h0000, 16'h0000, 16'h8000, 16'h8000);
        wait_latency();
        chk("prodsat_out0", out0, 16'h0000);
        chk("prodsat_out1", out1, 16'h7FFF);
        chk("prodsat_out2", out2, 16'h0000);
        chk("prodsat_out3", out3, 16'h8001);

        // Back-to-back stream: {wr, wi, ar, ai, br, bi}
        vec[0] = '{16'h0400, 16'h0000, 16'h0100, 16'hFF00, 16'h0200, 16'h0300};
        vec[1] = '{16'h02D4, 16'hFD2C, 16'h1234, 16'h0567, 16'h0ABC, 16'hF123};
        vec[2] = '{16'h0000, 16'h0400, 16'hF000, 16'h0800, 16'h0C00, 16'hF400};
        vec[3] = '{16'hFC00, 16'h0000, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h7FFF};
        vec[4] = '{16'h7FFF, 16'h7FFF, 16'h0010, 16'h0020, 16'h0040, 16'hFFC0};
        vec[5] = '{16'h0123, 16'hFEDC, 16'h4000, 16'hC000, 16'h3FFF, 16'hC001};
        vec[6] = '{16'h0200, 16'h0200, 16'h0001, 16'hFFFF, 16'hFFFF, 16'h0001};
        vec[7] = '{16'h8000, 16'h0000, 16'h0000, 16'h0000, 16'h0001, 16'h0400};
        vec[8] = '{16'h03FF, 16'h0001, 16'h5555, 16'hAAAA, 16'h1111, 16'hEEEE};
        vec[9] = '{16'hFE00, 16'h0100, 16'hFFF0, 16'h0010, 16'h7000, 16'h9000};
        for (int k = 0; k < 12; k++) begin
            if (k >= 2) begin
                expv = ref_bfly(vec[k-2][0], vec[k-2][1], vec[k-2][2],
                                vec[k-2][3], vec[k-2][4], vec[k-2][5]);
                chk($sformatf("stream%0d_out0", k - 2), out0, expv[63:48]);
                chk($sformatf("stream%0d_out1", k - 2), out1, expv[47:32]);
                chk($sformatf("stream%0d_out2", k - 2), out2, expv[31:16]);
                chk($sformatf("stream%0d_out3", k - 2), out3, expv[15:0]);
            end
            if (k < 10) begin
                drive(vec[k][0], vec[k][1], vec[k][2], vec[k][3], vec[k][4], vec[k][5]);
            end
            @(negedge clk);
        end

        // Mid-stream asynchronous reset with nonzero data in flight
        drive(16'h0400, 16'h0000, 16'h1000, 16'h2000, 16'h0100, 16'h0200);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out0", out0, 16'h0000);
        chk("midrst_out1", out1, 16'h0000);
        chk("midrst_out2", out2, 16'h0000);
        chk("midrst_out3", out3, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        // First edge after release samples the held inputs; outputs still 0.
        @(posedge clk);
        @(negedge clk);
        chk("post_rst_e1_out0", out0, 16'h0000);
        chk("post_rst_e1_out1", out1, 16'h0000);
        @(posedge clk);
        @(negedge clk);
        chk("post_rst_e2_out0", out0, 16'h1100);
        chk("post_rst_e2_out1", out1, 16'h2200);
        chk("post_rst_e2_out2", out2, 16'h0F00);
        chk("post_rst_e2_out3", out3, 16'h1E00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
